// File: rtl/mem_addr_decoder.sv
// Address decoder and response router from one core memory port to NUM_SLAVES targets.
// Optional slave timeout is compiled in with `define MEM_DECODER_TIMEOUT_EN.
module mem_addr_decoder #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0] BASE_ADDR =
        {32'h8000_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] TOP_ADDR =
        {32'h9000_0000, 32'h0200_C000, 32'h0100_0004, 32'h0000_0080},
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     m_valid,
    input  logic                     m_instr,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic [31:0]              m_rdata,
    output logic                     m_ready,
    output logic                     m_error,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic                     s_instr,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [NUM_SLAVES*32-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    output logic                     overrun
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [SEL_W-1:0]        r_sel;
    logic                    r_instr;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wstrb;
    logic [31:0]             r_rdata;
    logic                    r_error;
    logic                    r_overrun;

    logic                    w_hit;
    logic [SEL_W-1:0]        w_hit_sel;
    logic                    w_sel_ready;
    logic [31:0]             w_sel_rdata;
    logic [NUM_SLAVES-1:0]   w_sel_onehot;
    logic                    w_expire;

    // Ascending scan with a found flag gives the lowest index priority on overlap.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!w_hit && (m_addr >= BASE_ADDR[i*32 +: 32]) && (m_addr < TOP_ADDR[i*32 +: 32])) begin
                w_hit     = 1'b1;
                w_hit_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_ready  = 1'b0;
        w_sel_rdata  = '0;
        w_sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (SEL_W'(i) == r_sel) begin
                w_sel_ready     = s_ready[i];
                w_sel_rdata     = s_rdata[i*32 +: 32];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

`ifdef MEM_DECODER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Expiry is flagged in the WAIT cycle whose increment would reach the limit.
    assign w_expire = (r_state == WAIT) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == REQ) begin
            r_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (m_valid) w_next_state = w_hit ? REQ : RESP;
            REQ:  w_next_state = WAIT;
            WAIT: if (w_sel_ready || w_expire) w_next_state = RESP;
            RESP: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_instr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_error   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (m_valid && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (m_valid) begin
                        r_instr <= m_instr;
                        r_addr  <= m_addr;
                        r_wdata <= m_wdata;
                        r_wstrb <= m_wstrb;
                        r_sel   <= w_hit_sel;
                        r_error <= !w_hit;
                        if (!w_hit) begin
                            r_rdata <= '0;
                        end
                    end
                end
                WAIT: begin
                    // A response in the expiry cycle takes precedence over the timeout.
                    if (w_sel_ready) begin
                        r_rdata <= w_sel_rdata;
                        r_error <= 1'b0;
                    end else if (w_expire) begin
                        r_rdata <= '0;
                        r_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_ready = (r_state == RESP);
    assign m_error = (r_state == RESP) && r_error;
    assign m_rdata = r_rdata;
    assign s_valid = (r_state == REQ) ? w_sel_onehot : '0;
    assign s_instr = r_instr;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;
    assign s_wstrb = r_wstrb;
    assign overrun = r_overrun;

endmodule
